// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program counter feeding an instruction memory. The counter can be
//   cleared, loaded, incremented or decremented (modulo 2^W). The memory is
//   written synchronously through a separate write port and read
//   asynchronously at the current counter value, so r_data tracks q with no
//   added latency.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous active-low reset of the counter (memory is kept)
//   syn_clr   synchronous clear (highest priority)
//   load      synchronous load of d
//   en, up    count enable and direction (1 = increment)
//   d         counter load value
//   wr_en     memory write enable
//   w_addr    memory write address
//   w_data    memory write data
//   q         program counter
//   max_tick  q == 2^W-1
//   min_tick  q == 0
//   r_data    mem[q]
module pc_fetch_unit #(
  parameter int B = 16,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] d,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  output logic [W-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic [B-1:0] r_data
);

  localparam int DEPTH = 2 ** W;

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;
  logic [B-1:0] mem [DEPTH];

  always_comb begin
    q_next = q_reg;
    if (syn_clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (en && up) begin
      q_next = q_reg + 1'b1;
    end else if (en) begin
      q_next = q_reg - 1'b1;
    end
  end

  // The memory write shares the reset-qualified process with the counter so
  // that writes are simply not performed while reset is low, without using
  // reset as a synchronous data input. The memory itself is never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
      if (wr_en) begin
        mem[w_addr] <= w_data;
      end
    end
  end

  assign q        = q_reg;
  assign max_tick = (q_reg == {W{1'b1}});
  assign min_tick = (q_reg == '0);
  assign r_data   = mem[q_reg];

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int B = 16;
  localparam int W = 11;

  logic         clk;
  logic         reset;
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [W-1:0] d;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [B-1:0] w_data;
  logic [W-1:0] q;
  logic         max_tick;
  logic         min_tick;
  logic [B-1:0] r_data;

  pc_fetch_unit #(.B(B), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .syn_clr  (syn_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .d        (d),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .q        (q),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .r_data   (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [W-1:0] d;
    logic         wr_en;
    logic [W-1:0] w_addr;
    logic [B-1:0] w_data;
    logic [W-1:0] exp_q;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         max_t;
    logic         min_t;
    logic [B-1:0] data;
    logic         data_valid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Reference memory: only words the bench has written are compared.
  logic [B-1:0] mem_m [2**W];
  logic         mem_v [2**W];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic sc, input logic ld, input logic e,
                              input logic u, input logic [W-1:0] dv, input logic we,
                              input logic [W-1:0] wa, input logic [B-1:0] wd,
                              input logic [W-1:0] eq);
    vec_t v;
    v.name = nm; v.syn_clr = sc; v.load = ld; v.en = e; v.up = u; v.d = dv;
    v.wr_en = we; v.w_addr = wa; v.w_data = wd; v.exp_q = eq;
    return v;
  endfunction

  task automatic idle_inputs();
    syn_clr = 0; load = 0; en = 0; up = 0; d = '0;
    wr_en = 0; w_addr = '0; w_data = '0;
  endtask

  // Drive one vector, push its expectation, clock once, then pop and compare.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t g;
    syn_clr = v.syn_clr; load = v.load; en = v.en; up = v.up; d = v.d;
    wr_en = v.wr_en; w_addr = v.w_addr; w_data = v.w_data;
    if (v.wr_en && reset) begin
      mem_m[v.w_addr] = v.w_data;
      mem_v[v.w_addr] = 1'b1;
    end
    e.name       = v.name;
    e.q          = v.exp_q;
    e.max_t      = (v.exp_q == 11'h7FF);
    e.min_t      = (v.exp_q == 11'h000);
    e.data       = mem_m[v.exp_q];
    e.data_valid = mem_v[v.exp_q];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", v.name);
    end else begin
      g = sb.pop_front();
      chk({g.name, "_q"}, 32'(q), 32'(g.q));
      chk({g.name, "_max"}, 32'(max_tick), 32'(g.max_t));
      chk({g.name, "_min"}, 32'(min_tick), 32'(g.min_t));
      if (g.data_valid) chk({g.name, "_rdata"}, 32'(r_data), 32'(g.data));
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 2**W; i++) begin
      mem_m[i] = '0;
      mem_v[i] = 1'b0;
    end
    idle_inputs();
    reset = 1'b0;
    #2;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_min", 32'(min_tick), 32'h1);
    chk("rst_max", 32'(max_tick), 32'h0);

    // Controls and a write while reset is low: counter must stay 0.
    load = 1; d = 11'h123; en = 1; up = 1; wr_en = 1; w_addr = '0; w_data = 16'hFFFF;
    @(posedge clk); #1;
    chk("rst_hold_q", 32'(q), 32'h0);
    idle_inputs();
    reset = 1'b1;

    // Fill memory with the counter held.
    vecs.push_back(mk("wr0",   0, 0, 0, 0, 0, 1, 11'h000, 16'h1000, 11'h000));
    vecs.push_back(mk("wr1",   0, 0, 0, 0, 0, 1, 11'h001, 16'h1001, 11'h000));
    vecs.push_back(mk("wr2",   0, 0, 0, 0, 0, 1, 11'h002, 16'h1002, 11'h000));
    vecs.push_back(mk("wr3",   0, 0, 0, 0, 0, 1, 11'h003, 16'h1003, 11'h000));
    vecs.push_back(mk("wr4",   0, 0, 0, 0, 0, 1, 11'h004, 16'hAAAA, 11'h000));
    vecs.push_back(mk("wr7fe", 0, 0, 0, 0, 0, 1, 11'h7FE, 16'hCAFE, 11'h000));
    vecs.push_back(mk("wr7ff", 0, 0, 0, 0, 0, 1, 11'h7FF, 16'hBEEF, 11'h000));
    run_vecs();

    // Reset pulse leaves memory intact; r_data shows mem[0].
    reset = 1'b0;
    #1;
    chk("rst2_q", 32'(q), 32'h0);
    chk("rst2_rdata", 32'(r_data), 32'h1000);
    reset = 1'b1;

    vecs.push_back(mk("up1", 0, 0, 1, 1, 0, 0, 0, 0, 11'h001));
    vecs.push_back(mk("up2", 0, 0, 1, 1, 0, 0, 0, 0, 11'h002));
    vecs.push_back(mk("up3", 0, 0, 1, 1, 0, 0, 0, 0, 11'h003));
    vecs.push_back(mk("up4", 0, 0, 1, 1, 0, 0, 0, 0, 11'h004));
    run_vecs();

    // Write to the word currently addressed by q.
    wr_en = 1; w_addr = 11'h004; w_data = 16'h5555;
    #1;
    chk("wrq_before", 32'(r_data), 32'hAAAA);
    @(posedge clk); #1;
    mem_m[4] = 16'h5555;
    chk("wrq_after", 32'(r_data), 32'h5555);
    chk("wrq_q", 32'(q), 32'h4);
    idle_inputs();

    vecs.push_back(mk("ld7fe",   0, 1, 0, 0, 11'h7FE, 0, 0, 0, 11'h7FE));
    vecs.push_back(mk("up7ff",   0, 0, 1, 1, 0, 0, 0, 0, 11'h7FF));
    vecs.push_back(mk("wrap_up", 0, 0, 1, 1, 0, 0, 0, 0, 11'h000));
    vecs.push_back(mk("wrap_dn", 0, 0, 1, 0, 0, 0, 0, 0, 11'h7FF));
    vecs.push_back(mk("clr_pri", 1, 1, 1, 1, 11'h005, 0, 0, 0, 11'h000));
    vecs.push_back(mk("ld5",     0, 1, 0, 0, 11'h005, 0, 0, 0, 11'h005));
    vecs.push_back(mk("hold5",   0, 0, 0, 1, 0, 0, 0, 0, 11'h005));
    vecs.push_back(mk("ld_pri",  0, 1, 1, 1, 11'h009, 0, 0, 0, 11'h009));
    vecs.push_back(mk("wr_cnt",  0, 0, 1, 1, 0, 1, 11'h00A, 16'h1234, 11'h00A));
    vecs.push_back(mk("wr_dn",   0, 0, 1, 0, 0, 1, 11'h003, 16'h2222, 11'h009));
    vecs.push_back(mk("dn8",     0, 0, 1, 0, 0, 0, 0, 0, 11'h008));
    vecs.push_back(mk("up9",     0, 0, 1, 1, 0, 0, 0, 0, 11'h009));
    run_vecs();

    // Reset mid-count between edges, write ignored while low, resume from 0.
    en = 1; up = 1;
    #3;
    reset = 1'b0;
    #1;
    chk("async_q", 32'(q), 32'h0);
    chk("async_min", 32'(min_tick), 32'h1);
    chk("async_rdata", 32'(r_data), 32'h1000);
    wr_en = 1; w_addr = 11'h000; w_data = 16'hFFFF;
    @(posedge clk); #1;
    chk("async_hold_q", 32'(q), 32'h0);
    chk("async_nowr", 32'(r_data), 32'h1000);
    wr_en = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("resume_q", 32'(q), 32'h1);
    chk("resume_rdata", 32'(r_data), 32'h1001);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter B, default 16, instruction/data word width in bits.
REQ-002 Parameter W, default 11, address and counter width in bits; memory depth 2^W words.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset of counter state.
REQ-006 syn_clr  input  1  synchronous counter clear.
REQ-007 load  input  1  synchronous parallel load of counter from d.
REQ-008 en  input  1  count enable.
REQ-009 up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-010 d  input  W  counter load value.
REQ-011 wr_en  input  1  memory write enable.
REQ-012 w_addr  input  W  memory write address.
REQ-013 w_data  input  B  memory write data.
REQ-014 q  output  W  current counter value (program counter).
REQ-015 max_tick  output  1  high when q = 2^W-1.
REQ-016 min_tick  output  1  high when q = 0.
REQ-017 r_data  output  B  memory word addressed by q.

Function
REQ-018 Counter next-state priority per rising edge: syn_clr -> 0; else load -> d; else en&up -> q+1; else en&~up -> q-1; else hold.
REQ-019 Arithmetic SHALL be modulo 2^W: 2^W-1 + 1 wraps to 0; 0 - 1 wraps to 2^W-1; no carry/borrow output.
REQ-020 syn_clr SHALL override load and en when asserted together; load SHALL override en.
REQ-021 max_tick and min_tick SHALL be combinational decodes of q, no added latency.
REQ-022 Memory SHALL be a 2^W x B array with synchronous write: on rising edge with wr_en=1 and reset=1, mem[w_addr] <= w_data.
REQ-023 Memory read SHALL be asynchronous: r_data = mem[q] combinationally, i.e., r_data changes in the same cycle q changes.
REQ-024 Write to address equal to q: r_data SHALL show old word until the write edge, then new word immediately after that edge.
REQ-025 Simultaneous write and counter update on one edge: write uses w_addr as sampled; r_data afterward reflects mem[new q] including that write if addresses match.
REQ-026 Memory contents are uninitialised at power-up; only writes define them.

Reset
REQ-027 reset=0 SHALL force q=0 immediately, independent of clk; min_tick=1, max_tick=0 (for W>=1).
REQ-028 While reset=0, counter SHALL hold 0 regardless of syn_clr/load/en, and memory writes SHALL be ignored.
REQ-029 Memory contents SHALL NOT be altered by reset; r_data during reset equals mem[0].
REQ-030 Reset asserted mid-count SHALL take effect without waiting for an edge; counting resumes from 0 on the first rising edge after reset deasserts.

Verification
REQ-031 Reset 0, then 1; en=1, up=1, no other controls -> q = 0,1,2,3 on successive edges; min_tick=1 only at q=0.
REQ-032 Write mem[0..3] = 16'h1000,16'h1001,16'h1002,16'h1003 with counter held (en=0), then reset and count up -> r_data = 1000,1001,1002,1003 in step with q.
REQ-033 load=1, d=11'h7FE, then en=1, up=1 -> q = 7FE, 7FF (max_tick=1), 000 (min_tick=1) on successive edges.
REQ-034 q=0, en=1, up=0 -> q=7FF next edge; syn_clr=1 with load=1, d=5, en=1 -> q=0.
REQ-035 q=9 counting up, drop reset between edges -> q=0 at once, before next edge; release -> q=1 after first edge.
REQ-036 q=4 held, mem[4]=16'hAAAA; write w_addr=4, w_data=16'h5555 -> r_data=AAAA before edge, 5555 after edge.
